// File: rtl/ddr3_clk_rst_seq.sv
// Reset sequencer for the DDR3 PLL domain: qualifies PLL lock, releases the DDR3
// controller reset, waits for calibration, then releases the system reset.
module ddr3_clk_rst_seq #(
  parameter int LOCK_STABLE  = 1024,
  parameter int DDR_RST_HOLD = 200,
  parameter int CAL_TIMEOUT  = 1048576,
  parameter int RETRY_MAX    = 3,
  parameter int CNT_W        = 21
) (
  input  logic       init_clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       cal_done,
  input  logic       clr_fault,
  output logic       ddr_rst_n,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STABLE    = 3'd1,
    S_DDR_RST   = 3'd2,
    S_WAIT_CAL  = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  // The WAIT_LOCK sample counts as the first stable cycle, so STABLE exits one early.
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(DDR_RST_HOLD - 1);
  localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_TIMEOUT - 1);
  localparam logic [1:0]       RETRY_LIM = 2'(RETRY_MAX);

  logic             r_lock_meta, r_lock_s;
  logic             r_cal_meta, r_cal_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_retry;
  logic             r_ddr_rst_n, r_sys_rst_n, r_ready, r_fault;
  logic             w_restart;

  always_ff @(posedge init_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_cal_meta  <= 1'b0;
      r_cal_s     <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
      r_cal_meta  <= cal_done;
      r_cal_s     <= r_cal_meta;
    end
  end

  // Lock loss beats timeout beats cal_done, so any restart pre-empts the RUN entry.
  always_comb begin
    w_restart = 1'b0;
    case (r_state)
      S_DDR_RST:  w_restart = !r_lock_s;
      S_WAIT_CAL: w_restart = !r_lock_s || (r_cnt == CAL_LAST);
      S_RUN:      w_restart = !r_lock_s || !r_cal_s;
      default:    w_restart = 1'b0;
    endcase
  end

  always_ff @(posedge init_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT_LOCK;
      r_cnt       <= '0;
      r_retry     <= 2'd0;
      r_ddr_rst_n <= 1'b0;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else if (w_restart) begin
      r_cnt       <= '0;
      r_ddr_rst_n <= 1'b0;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      if (r_retry < RETRY_LIM) begin
        r_retry <= r_retry + 2'd1;
        r_state <= S_WAIT_LOCK;
      end else begin
        r_state <= S_FAULT;
        r_fault <= 1'b1;
      end
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            r_state <= S_STABLE;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        S_STABLE: begin
          if (!r_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == LOCK_LAST) begin
            r_state <= S_DDR_RST;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DDR_RST: begin
          if (r_cnt == HOLD_LAST) begin
            r_state     <= S_WAIT_CAL;
            r_cnt       <= '0;
            r_ddr_rst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_CAL: begin
          if (r_cal_s) begin
            r_state     <= S_RUN;
            r_sys_rst_n <= 1'b1;
            r_ready     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RUN: ;
        S_FAULT: begin
          if (clr_fault) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
            r_retry <= 2'd0;
            r_fault <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_WAIT_LOCK;
          r_cnt       <= '0;
          r_ddr_rst_n <= 1'b0;
          r_sys_rst_n <= 1'b0;
          r_ready     <= 1'b0;
          r_fault     <= 1'b0;
        end
      endcase
    end
  end

  assign ddr_rst_n = r_ddr_rst_n;
  assign sys_rst_n = r_sys_rst_n;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign retry_cnt = r_retry;
  assign state_o   = r_state;

endmodule

// File: tb/tb_ddr3_clk_rst_seq.sv
// Bench for ddr3_clk_rst_seq: directed vector table, hand sequences for the
// simultaneous-event and async-reset cases, and random stimulus against a phase model.
module tb_ddr3_clk_rst_seq;
  localparam int LS = 8, HOLD = 4, CTO = 32, RMAX = 3;

  logic       init_clk = 1'b0, rst_n = 1'b0;
  logic       pll_lock = 1'b0, cal_done = 1'b0, clr_fault = 1'b0;
  logic       ddr_rst_n, sys_rst_n, ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  int n_chk = 0, n_fail = 0;
  bit mon_en = 1'b0;

  ddr3_clk_rst_seq #(.LOCK_STABLE(LS), .DDR_RST_HOLD(HOLD), .CAL_TIMEOUT(CTO),
                     .RETRY_MAX(RMAX), .CNT_W(6)) dut (
    .init_clk(init_clk), .rst_n(rst_n), .pll_lock(pll_lock), .cal_done(cal_done),
    .clr_fault(clr_fault), .ddr_rst_n(ddr_rst_n), .sys_rst_n(sys_rst_n),
    .ready(ready), .fault(fault), .retry_cnt(retry_cnt), .state_o(state_o));

  always #5 init_clk = ~init_clk;

  function automatic logic [8:0] obs();
    return {ddr_rst_n, sys_rst_n, ready, fault, retry_cnt, state_o};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phases named by the spec encodings, a run length of
  // consecutive synced-lock samples and an elapsed-time-in-phase count.
  int m_phase = 0, m_run = 0, m_el = 0, m_retry = 0;
  bit m_l1 = 0, m_l2 = 0, m_c1 = 0, m_c2 = 0, m_rs;

  always @(posedge init_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_run = 0; m_el = 0; m_retry = 0;
      m_l1 = 0; m_l2 = 0; m_c1 = 0; m_c2 = 0;
    end else begin
      m_rs = 0;
      case (m_phase)
        0: if (m_l2) begin m_phase = 1; m_run = 1; end
        1: if (!m_l2) m_phase = 0;
           else begin
             m_run++;
             if (m_run == LS) begin m_phase = 2; m_el = 0; end
           end
        2: if (!m_l2) m_rs = 1;
           else begin
             m_el++;
             if (m_el == HOLD) begin m_phase = 3; m_el = 0; end
           end
        3: if (!m_l2) m_rs = 1;
           else begin
             m_el++;
             if (m_el == CTO) m_rs = 1;
             else if (m_c2) m_phase = 4;
           end
        4: if (!m_l2 || !m_c2) m_rs = 1;
        5: if (clr_fault) begin m_phase = 0; m_retry = 0; end
        default: m_phase = 0;
      endcase
      if (m_rs) begin
        if (m_retry < RMAX) begin m_retry++; m_phase = 0; end
        else m_phase = 5;
      end
      m_l2 = m_l1; m_l1 = pll_lock;
      m_c2 = m_c1; m_c1 = cal_done;
    end
  end

  function automatic logic [8:0] model_obs();
    logic d, s, f;
    d = (m_phase == 3) || (m_phase == 4);
    s = (m_phase == 4);
    f = (m_phase == 5);
    return {d, s, s, f, 2'(m_retry), 3'(m_phase)};
  endfunction

  logic       prev_ddr = 1'b0;
  logic [2:0] prev_st  = 3'd0;
  always @(negedge init_clk) begin
    if (mon_en) begin
      check("model", 32'(obs()), 32'(model_obs()));
      check("inv_sys_implies_ddr", 32'(sys_rst_n & ~ddr_rst_n), 32'd0);
      check("inv_ready_eq_sys", 32'(ready), 32'(sys_rst_n));
      if (ddr_rst_n && !prev_ddr)
        check("inv_ddr_rise", 32'({prev_st, state_o}), 32'({3'd2, 3'd3}));
    end
    prev_ddr = ddr_rst_n;
    prev_st  = state_o;
  end

  typedef struct {
    int         n;
    logic       lock, cal, clr;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int n, input bit l, input bit c, input bit clr,
                              input bit d, input bit s, input bit f,
                              input int rt, input int st);
    vec_t v;
    v.n = n; v.lock = l; v.cal = c; v.clr = clr;
    v.exp = {d, s, s, f, 2'(rt), 3'(st)};
    tbl.push_back(v);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge init_clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    for (int k = 0; k < 100 && state_o !== s; k++) tick(1);
    check(nm, 32'(state_o), 32'(s));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // n lock cal clr | ddr sys fault retry state
    add(2, 1,0,0, 0,0,0, 0,0);  add(1, 1,0,0, 0,0,0, 0,1);
    add(6, 1,0,0, 0,0,0, 0,1);  add(1, 1,0,0, 0,0,0, 0,2);
    add(3, 1,0,0, 0,0,0, 0,2);  add(1, 1,0,0, 1,0,0, 0,3);
    add(5, 1,0,0, 1,0,0, 0,3);  add(2, 1,1,0, 1,0,0, 0,3);
    add(1, 1,1,0, 1,1,0, 0,4);
    add(2, 0,1,0, 1,1,0, 0,4);  add(1, 0,1,0, 0,0,0, 1,0);
    add(3, 0,0,0, 0,0,0, 1,0);
    add(5, 1,0,0, 0,0,0, 1,1);  add(1, 0,0,0, 0,0,0, 1,1);
    add(1, 1,0,0, 0,0,0, 1,1);  add(1, 1,0,0, 0,0,0, 1,0);
    add(1, 1,0,0, 0,0,0, 1,1);  add(6, 1,0,0, 0,0,0, 1,1);
    add(1, 1,0,0, 0,0,0, 1,2);  add(3, 1,0,0, 0,0,0, 1,2);
    add(1, 1,0,0, 1,0,0, 1,3);
    add(31, 1,0,0, 1,0,0, 1,3); add(1, 1,0,0, 0,0,0, 2,0);
    add(44, 1,0,0, 0,0,0, 3,0); add(43, 1,0,0, 1,0,0, 3,3);
    add(1, 1,0,0, 0,0,1, 3,5);  add(5, 1,1,0, 0,0,1, 3,5);
    add(1, 1,0,1, 0,0,0, 0,0);  add(1, 1,0,0, 0,0,0, 0,1);

    tick(3);
    check("reset_state", 32'(obs()), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    foreach (tbl[i]) begin
      pll_lock = tbl[i].lock; cal_done = tbl[i].cal; clr_fault = tbl[i].clr;
      tick(tbl[i].n);
      check($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
    end
    clr_fault = 1'b0;

    // Lock loss and cal_done land on the synced inputs in the same WAIT_CAL cycle.
    pll_lock = 1'b0; cal_done = 1'b0;
    pulse_reset();
    pll_lock = 1'b1;
    wait_state(3'd3, "simul_reach_wait_cal");
    pll_lock = 1'b0; cal_done = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check("simul_ready_low", 32'(ready), 32'd0);
    end
    check("simul_restart", 32'({retry_cnt, state_o}), 32'({2'd1, 3'd0}));

    // Async reset between edges while in WAIT_CAL with a retry already charged.
    cal_done = 1'b0; pll_lock = 1'b1;
    wait_state(3'd3, "async_reach_wait_cal");
    @(posedge init_clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", 32'(obs()), 32'd0);
    tick(2);
    rst_n = 1'b1;

    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 39) == 0) pll_lock = ~pll_lock;
      if ($urandom_range(0, 24) == 0) cal_done = ~cal_done;
      clr_fault = ($urandom_range(0, 29) == 0);
      tick(1);
    end
    clr_fault = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
